// File: rtl/btn_cond_pkg.sv
// rtl/btn_cond_pkg.sv - shared repeat-FSM encodings and default timing for the button conditioner
package btn_cond_pkg;

   typedef enum logic [1:0] {
      ST_REL  = 2'd0,
      ST_WAIT = 2'd1,
      ST_RPT  = 2'd2
   } rpt_state_t;

   localparam int DEF_N_BTN        = 3;
   localparam int DEF_DB_CYCLES    = 1_000_000;
   localparam int DEF_REPEAT_DELAY = 50_000_000;
   localparam int DEF_REPEAT_RATE  = 10_000_000;

   // A count of 1 still needs a one-bit register.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: 2-flop sync, debounce counter, edge pulses and auto-repeat FSM
module btn_channel
   import btn_cond_pkg::*;
#(
   parameter int DB_CYCLES    = DEF_DB_CYCLES,
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_repeat
);

   localparam int DW   = cnt_width(DB_CYCLES);
   localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int TW   = cnt_width(TMAX);

   localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
   localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

   logic [1:0]    r_sync;
   logic [DW-1:0] r_db_cnt;
   logic          r_level;
   logic          r_press;
   logic          r_release;
   logic          r_repeat;
   logic [TW-1:0] r_timer;
   rpt_state_t    r_state;

   logic w_edge;
   logic w_rise;
   logic w_fall;

   // The debounced level flips on this cycle's edge.
   assign w_edge = (r_sync[1] != r_level) && (r_db_cnt == DB_LAST);
   assign w_rise = w_edge & ~r_level;
   assign w_fall = w_edge &  r_level;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync    <= '0;
         r_db_cnt  <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], i_raw};
         r_press   <= w_rise;
         r_release <= w_fall;
         if (r_sync[1] == r_level || w_edge) begin
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
         if (w_edge) begin
            r_level <= ~r_level;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_REL;
         r_timer  <= '0;
         r_repeat <= 1'b0;
      end else begin
         r_repeat <= 1'b0;
         if (w_fall) begin
            r_state <= ST_REL;
            r_timer <= '0;
         end else begin
            case (r_state)
               ST_REL: begin
                  r_timer <= '0;
                  if (w_rise) begin
                     r_state  <= ST_WAIT;
                     r_repeat <= 1'b1;
                  end
               end
               ST_WAIT: begin
                  if (r_timer == DELAY_LAST) begin
                     r_state  <= ST_RPT;
                     r_repeat <= 1'b1;
                     r_timer  <= '0;
                  end else begin
                     r_timer <= r_timer + 1'b1;
                  end
               end
               ST_RPT: begin
                  if (r_timer == RATE_LAST) begin
                     r_repeat <= 1'b1;
                     r_timer  <= '0;
                  end else begin
                     r_timer <= r_timer + 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_REL;
                  r_timer <= '0;
               end
            endcase
         end
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_repeat  = r_repeat;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - N_BTN independent button channels side by side
module btn_conditioner
   import btn_cond_pkg::*;
#(
   parameter int N_BTN        = DEF_N_BTN,
   parameter int DB_CYCLES    = DEF_DB_CYCLES,
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat
);

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      btn_channel #(
         .DB_CYCLES   (DB_CYCLES),
         .REPEAT_DELAY(REPEAT_DELAY),
         .REPEAT_RATE (REPEAT_RATE)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .i_raw    (btn_raw[g]),
         .o_level  (btn_level[g]),
         .o_press  (btn_press[g]),
         .o_release(btn_release[g]),
         .o_repeat (btn_repeat[g])
      );
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed bench with a sample-history model of the button conditioner
module tb_btn_conditioner;

   localparam int N  = 3;
   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RR = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] btn_raw = '0;
   logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;

   int n_cmp = 0;
   int n_err = 0;
   int g_act = 0;
   int rep_t[$];

   btn_conditioner #(
      .N_BTN(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw),
      .btn_level(btn_level), .btn_press(btn_press),
      .btn_release(btn_release), .btn_repeat(btn_repeat)
   );

   always #5 clk = ~clk;

   // Model: m_hist[k] is the raw value captured k edges ago; a channel's level
   // flips once the last DB synchronised samples all disagree with it.
   logic [N-1:0] m_hist [0:DB] = '{default: '0};
   logic [N-1:0] m_level = '0, m_press = '0, m_rel = '0, m_rep = '0;
   int           m_held [N] = '{default: 0};

   function automatic bit all_differ(input int c);
      for (int k = 1; k <= DB; k++)
         if (m_hist[k][c] == m_level[c]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit rep_due(input int t);
      return (t == RD) || (t > RD && ((t - RD) % RR) == 0);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_hist  <= '{default: '0};
         m_level <= '0; m_press <= '0; m_rel <= '0; m_rep <= '0;
         m_held  <= '{default: 0};
      end else begin
         m_hist[0] <= btn_raw;
         for (int k = 1; k <= DB; k++) m_hist[k] <= m_hist[k-1];
         for (int c = 0; c < N; c++) begin
            if (all_differ(c)) begin
               m_level[c] <= ~m_level[c];
               m_press[c] <= ~m_level[c];
               m_rel[c]   <=  m_level[c];
               m_rep[c]   <= ~m_level[c];
               m_held[c]  <= 0;
            end else begin
               m_press[c] <= 1'b0;
               m_rel[c]   <= 1'b0;
               m_held[c]  <= m_level[c] ? m_held[c] + 1 : 0;
               m_rep[c]   <= m_level[c] && rep_due(m_held[c] + 1);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("level", 32'(btn_level),   32'(m_level));
      check("press", 32'(btn_press),   32'(m_press));
      check("release", 32'(btn_release), 32'(m_rel));
      check("repeat", 32'(btn_repeat),  32'(m_rep));
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (|{btn_level, btn_press, btn_release, btn_repeat}) g_act++;
      end
   endtask

   task automatic watch(input int ncyc, input int ch, output int t_press, output int t_rel,
                        output int n_press, output int n_rel, output int n_other);
      t_press = -1; t_rel = -1; n_press = 0; n_rel = 0; n_other = 0;
      rep_t.delete();
      for (int i = 1; i <= ncyc; i++) begin
         @(posedge clk); #1;
         if (btn_press[ch]) begin n_press++; if (t_press < 0) t_press = i; end
         if (btn_release[ch]) begin n_rel++; if (t_rel < 0) t_rel = i; end
         if (btn_repeat[ch]) rep_t.push_back(i);
         for (int c = 0; c < N; c++)
            if (c != ch && (btn_level[c] | btn_press[c] | btn_release[c] | btn_repeat[c])) n_other++;
      end
   endtask

   initial begin
      int tp, tr, np, nr, no, t0, t2;
      int exp_rep[6] = '{6, 26, 34, 42, 50, 58};

      @(posedge clk); #1;
      check("reset_outputs", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'd0);
      tick(2);
      rst = 1'b0;
      tick(3);

      // clean press on channel 1
      btn_raw[1] = 1'b1;
      watch(10, 1, tp, tr, np, nr, no);
      check("clean_press_latency", tp, 6);
      check("clean_press_count", np, 1);
      check("clean_repeat_at_press", (rep_t.size() > 0) ? rep_t[0] : -1, 6);
      check("clean_other_channels", no, 0);
      btn_raw[1] = 1'b0;
      tick(12);

      // bounce on channel 0
      g_act = 0;
      btn_raw[0] = 1'b1; tick(2);
      btn_raw[0] = 1'b0; tick(2);
      btn_raw[0] = 1'b1; tick(2);
      btn_raw[0] = 1'b0; tick(2);
      check("bounce_no_activity", g_act, 0);
      btn_raw[0] = 1'b1;
      watch(12, 0, tp, tr, np, nr, no);
      check("bounce_press_latency", tp, 6);
      check("bounce_press_count", np, 1);
      btn_raw[0] = 1'b0;
      tick(12);

      // short glitch on channel 1
      g_act = 0;
      btn_raw[1] = 1'b1; tick(3);
      btn_raw[1] = 1'b0; tick(12);
      check("glitch_no_activity", g_act, 0);

      // auto-repeat on channel 2
      btn_raw[2] = 1'b1;
      watch(60, 2, tp, tr, np, nr, no);
      check("rpt_press_latency", tp, 6);
      check("rpt_count", rep_t.size(), 6);
      for (int k = 0; k < 6; k++)
         check("rpt_time", (k < rep_t.size()) ? rep_t[k] : -1, exp_rep[k]);
      btn_raw[2] = 1'b0;
      watch(12, 2, tp, tr, np, nr, no);
      check("rpt_release_latency", tr, 6);
      check("rpt_none_after_fall", rep_t.size(), 0);

      // reset while repeating, button still held
      btn_raw[2] = 1'b1;
      watch(30, 2, tp, tr, np, nr, no);
      check("rst_hold_press", tp, 6);
      check("rst_hold_in_rpt", rep_t.size(), 2);
      #2 rst = 1'b1;
      #1 check("rst_async_clear", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'd0);
      tick(3);
      rst = 1'b0;
      watch(10, 2, tp, tr, np, nr, no);
      check("rst_repress_latency", tp, 6);
      check("rst_no_release", nr, 0);
      btn_raw[2] = 1'b0;
      tick(12);

      // simultaneous presses on channels 0 and 2
      t0 = -1; t2 = -1;
      btn_raw = 3'b101;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (btn_press[0] && t0 < 0) t0 = i;
         if (btn_press[2] && t2 < 0) t2 = i;
      end
      check("simul_press0", t0, 6);
      check("simul_press2", t2, 6);
      btn_raw = '0;
      tick(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 3, number of button channels (bit 0 reset, bit 1 up, bit 2 down).
REQ-002 SHALL have parameter DB_CYCLES, default 1_000_000, stable-sample count for debounce (10 ms at 100 MHz).
REQ-003 SHALL have parameter REPEAT_DELAY, default 50_000_000, cycles from press to first auto-repeat.
REQ-004 SHALL have parameter REPEAT_RATE, default 10_000_000, cycles between subsequent auto-repeats.
REQ-005 SHALL have port clk, input, 1, the single system clock; all logic is in this domain.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port btn_raw, input, N_BTN, asynchronous raw board buttons, active-high.
REQ-008 SHALL have port btn_level, output, N_BTN, debounced button level.
REQ-009 SHALL have port btn_press, output, N_BTN, one-cycle pulse on debounced rise.
REQ-010 SHALL have port btn_release, output, N_BTN, one-cycle pulse on debounced fall.
REQ-011 SHALL have port btn_repeat, output, N_BTN, one-cycle pulse on press and then periodically while held.

Function
REQ-012 Each channel SHALL pass btn_raw through a 2-flop synchronizer; only the second flop (sync) feeds the logic.
REQ-013 Debounce counter SHALL clear whenever sync equals btn_level, and increment when it differs.
REQ-014 When sync has differed from btn_level for DB_CYCLES consecutive cycles, btn_level SHALL toggle on that edge and the counter SHALL clear.
REQ-015 Latency from a clean raw edge to btn_level change SHALL be exactly 2 + DB_CYCLES cycles.
REQ-016 Glitches or bounces shorter than DB_CYCLES cycles SHALL produce no output change.
REQ-017 All outputs SHALL be registered; btn_press and btn_release SHALL assert in the same cycle btn_level changes.
REQ-018 Per-channel repeat FSM states: REL, WAIT, RPT.
REQ-019 REL -> WAIT on debounced rise: btn_repeat pulses, repeat timer clears.
REQ-020 In WAIT, when the timer reaches REPEAT_DELAY-1: btn_repeat pulses, timer clears, go to RPT.
REQ-021 In RPT, every REPEAT_RATE cycles: btn_repeat pulses and the timer clears.
REQ-022 A debounced fall in any state SHALL force REL with no repeat pulse in that cycle.
REQ-023 Counter widths SHALL be $clog2 of the respective parameter, with no wrap before terminal count.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels each behave as if alone.

Reset
REQ-025 While rst is high: synchronizers, counters and timers are 0; FSMs are in REL; all outputs are 0, asynchronously.
REQ-026 If a button is held through reset release, it SHALL be treated as a new press: btn_level rises 2 + DB_CYCLES cycles after rst falls, with btn_press and btn_repeat pulses.
REQ-027 Reset asserted mid-press or mid-repeat SHALL produce no btn_release pulse.

Structure
REQ-028 Shared package btn_cond_pkg SHALL hold the FSM state encodings (REL, WAIT, RPT) and the default timing constants.
REQ-029 Per-channel logic SHALL be a sub-module btn_channel, instantiated N_BTN times via generate.
REQ-030 The top level SHALL only instantiate and concatenate; it contains no other logic.

Verification (bench parameters: DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-031 Clean press: btn_raw[1] 0->1 and held -> btn_level[1]=1 exactly 6 cycles later; btn_press[1] and btn_repeat[1] high for 1 cycle; other channels stay 0.
REQ-032 Bounce: btn_raw[0] toggling 1,0,1,0 every 2 cycles, then stable high -> single btn_press[0], 6 cycles after the last rising edge; no intermediate pulses.
REQ-033 Auto-repeat: btn_raw[2] held 60 cycles -> btn_repeat[2] at press, press+20, press+28, press+36 and so on; btn_release[2] 6 cycles after raw falls; no repeat pulse after the fall.
REQ-034 Short glitch: btn_raw[1] high for 3 cycles -> all outputs remain 0.
REQ-035 Reset mid-hold: rst pulsed during RPT with btn_raw held -> outputs 0 immediately, no release pulse; btn_press re-fires 6 cycles after rst deasserts.
REQ-036 Simultaneous: btn_raw[0] and btn_raw[2] rise on the same cycle -> btn_press[0] and btn_press[2] assert on the same cycle.
